// File: rtl/pattern_arb.sv
// Round-robin arbiter that serializes a 4-bit pattern frame per grant.
// Optional define PATTERN_ARB_FRAME_CNT_EN adds an 8-bit frame counter output.
module pattern_arb #(
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [1:0] sel0,
    input  logic [1:0] sel1,
    input  logic [1:0] sel2,
    input  logic [1:0] sel3,
    output logic [3:0] ack,
    output logic [1:0] gnt_id,
    output logic       ser_out,
    output logic       ser_valid,
`ifdef PATTERN_ARB_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        F0,
        F1,
        F2,
        F3,
        GAP
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] gap_cnt;
    logic [1:0] sel_q;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic [1:0] win_sel;

    // Upward search from ptr, wrapping 3->0; first set bit wins.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_sel = sel0;
        unique case (win)
            2'd0: win_sel = sel0;
            2'd1: win_sel = sel1;
            2'd2: win_sel = sel2;
            2'd3: win_sel = sel3;
        endcase
    end

    // Outputs are registered alongside the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gap_cnt   <= 4'd0;
            sel_q     <= 2'd0;
            gnt_id    <= 2'd0;
            ack       <= 4'd0;
            ser_out   <= 1'b1;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef PATTERN_ARB_FRAME_CNT_EN
            frame_cnt <= 8'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state     <= F0;
                        gnt_id    <= win;
                        sel_q     <= win_sel;
                        ptr       <= win + 2'd1;
                        ack       <= 4'b0001 << win;
                        ser_out   <= 1'b1;
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                F0: begin
                    state     <= F1;
                    ack       <= 4'd0;
                    ser_out   <= 1'b1;
                    ser_valid <= 1'b1;
                end
                F1: begin
                    state   <= F2;
                    ser_out <= sel_q[1];
                end
                F2: begin
                    state   <= F3;
                    ser_out <= sel_q[0];
`ifdef PATTERN_ARB_FRAME_CNT_EN
                    frame_cnt <= frame_cnt + 8'd1;
`endif
                end
                F3: begin
                    state     <= GAP;
                    gap_cnt   <= 4'd1;
                    ser_out   <= 1'b1;
                    ser_valid <= 1'b0;
                end
                GAP: begin
                    if (gap_cnt == 4'(IDLE_GAP)) begin
                        state   <= IDLE;
                        gap_cnt <= 4'd0;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_arb.sv
// Scoreboard bench for pattern_arb: directed frames, monitor pops and compares.
// Define PATTERN_ARB_FRAME_CNT_EN to also exercise the frame counter.
module tb_pattern_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel0, sel1, sel2, sel3;
    logic [3:0] ack;
    logic [1:0] gnt_id;
    logic       ser_out;
    logic       ser_valid;
    logic       busy;
`ifdef PATTERN_ARB_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    pattern_arb #(.IDLE_GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .ack       (ack),
        .gnt_id    (gnt_id),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
`ifdef PATTERN_ARB_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [1:0] id;
        logic [3:0] bits;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    // Monitor: assemble frames on ser_valid and compare with queued expectations.
    int         mcnt = 0;
    logic [3:0] mbits;
    int         last_start = 0;
    exp_t       cur;

    always @(negedge clk) begin
        if (!rst) begin
            if (mcnt != 0 && q.size() > 0) void'(q.pop_front());
            mcnt = 0;
        end else if (ser_valid) begin
            if (mcnt == 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    cur.id = gnt_id; cur.bits = 4'd0; cur.gap = 0;
                end else begin
                    cur = q[0];
                end
                chk("gnt_id", 32'(gnt_id), 32'(cur.id));
                chk("ack_f0", 32'(ack), 32'(4'b0001 << cur.id));
                if (cur.gap != 0)
                    chk("spacing", 32'(cyc - last_start), 32'(cur.gap));
                last_start = cyc;
            end else begin
                chk("ack_low", 32'(ack), 32'd0);
            end
            mbits = {mbits[2:0], ser_out};
            mcnt++;
            if (mcnt == 4) begin
                chk("frame_bits", 32'(mbits), 32'(cur.bits));
                if (q.size() > 0) void'(q.pop_front());
                mcnt = 0;
            end
        end else begin
            if (mcnt != 0) begin
                chk("truncated", 32'(mcnt), 32'd4);
                if (q.size() > 0) void'(q.pop_front());
                mcnt = 0;
            end
            chk("idle_line", 32'(ser_out), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req = req & ~ack;
    endtask

    task automatic wait_quiet();
        int n = 0;
        step();
        while ((busy || req != 4'd0) && n < 200) begin
            step();
            n++;
        end
        chk("quiet_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'd0;
        #1;
        chk("rst_ser_out", 32'(ser_out), 32'd1);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
`ifdef PATTERN_ARB_FRAME_CNT_EN
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // req raised in an IDLE cycle must show ser_valid the very next cycle.
    task automatic lat_chk();
        @(negedge clk);
        chk("lat_pre", 32'(ser_valid), 32'd0);
        @(negedge clk);
        chk("lat_post", 32'(ser_valid), 32'd1);
        req = 4'd0;
    endtask

    function automatic void push(input logic [1:0] id, input logic [3:0] b,
                                 input int gap);
        exp_t e;
        e.id = id; e.bits = b; e.gap = gap;
        q.push_back(e);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = 4'd0;
        sel0 = 2'd0; sel1 = 2'd0; sel2 = 2'd0; sel3 = 2'd0;
        #2;
        do_reset();

        // Single request, sel0=10 -> 1110
        sel0 = 2'b10;
        push(2'd0, 4'b1110, 0);
        req = 4'b0001;
        lat_chk();
        wait_quiet();
        chk("gnt_hold0", 32'(gnt_id), 32'd0);

        // All requesters held, order 0..3, 6 cycles apart
        do_reset();
        sel0 = 2'b00; sel1 = 2'b01; sel2 = 2'b10; sel3 = 2'b11;
        push(2'd0, 4'b1100, 0);
        push(2'd1, 4'b1101, 6);
        push(2'd2, 4'b1110, 6);
        push(2'd3, 4'b1111, 6);
        req = 4'b1111;
        wait_quiet();
        chk("gnt_hold3", 32'(gnt_id), 32'd3);

        // Round-robin wrap: after serving 2, req=0101 serves 0 then 2
        do_reset();
        sel0 = 2'b01; sel2 = 2'b10;
        push(2'd2, 4'b1110, 0);
        req = 4'b0100;
        wait_quiet();
        push(2'd0, 4'b1101, 0);
        push(2'd2, 4'b1110, 6);
        req = 4'b0101;
        wait_quiet();

        // sel change during F1 must not disturb the frame
        sel1 = 2'b11;
        push(2'd1, 4'b1111, 0);
        req = 4'b0010;
        step();
        step();
        sel1 = 2'b00;
        wait_quiet();

        // Reset in F2 aborts the frame; restart from requester 0 search
        sel0 = 2'b00;
        push(2'd0, 4'b1100, 0);
        req = 4'b0001;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("abort_ser_valid", 32'(ser_valid), 32'd0);
        chk("abort_ser_out", 32'(ser_out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sel3 = 2'b01;
        push(2'd3, 4'b1101, 0);
        req = 4'b1000;
        lat_chk();
        wait_quiet();

`ifdef PATTERN_ARB_FRAME_CNT_EN
        do_reset();
        sel0 = 2'b00;
        for (int i = 0; i < 257; i++) begin
            push(2'd0, 4'b1100, 0);
            req = 4'b0001;
            wait_quiet();
        end
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd1);
`endif

        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/pattern_arb.md
PATTERN_ARB -- requirements
Module: pattern_arb

Interface
REQ-001 Parameter IDLE_GAP, default 1, SHALL set the number of idle cycles inserted after each frame; legal range is 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 req  input  4  SHALL carry level requests, one bit per requester 0..3.
REQ-005 sel0..sel3  input  2 each  SHALL carry the 2-bit pattern select of requesters 0..3.
REQ-006 ack  output  4  SHALL be a one-hot, one-cycle grant-accept pulse to the served requester.
REQ-007 gnt_id  output  2  SHALL hold the index of the requester currently being served.
REQ-008 ser_out  output  1  SHALL be the serial frame bit.
REQ-009 ser_valid  output  1  SHALL mark the cycles in which ser_out carries a frame bit.
REQ-010 busy  output  1  SHALL be high whenever the block is not in IDLE.

Function
REQ-011 States SHALL be IDLE, F0, F1, F2, F3 and GAP.
REQ-012 IDLE with req==0 SHALL remain in IDLE.
REQ-013 IDLE with req!=0: winner SHALL be chosen round-robin, searching upward from pointer ptr with wrap 3->0.
- The winner's index SHALL be registered into gnt_id.
- The winner's sel SHALL be latched.
- The next state SHALL be F0.
REQ-014 ptr SHALL update to winner+1 (mod 4) at the grant edge; ptr SHALL be unchanged otherwise.
REQ-015 F0->F1->F2->F3 SHALL advance unconditionally, one cycle each; F3 SHALL go to GAP.
REQ-016 GAP SHALL last exactly IDLE_GAP cycles, counted by a 4-bit counter, then SHALL return to IDLE.
REQ-017 ser_out by state SHALL be:
- F0: 1
- F1: 1
- F2: latched sel[1]
- F3: latched sel[0]
- all other states: 1 (idle-high line)
REQ-018 ser_valid SHALL be 1 in F0..F3 only.
REQ-019 ack[gnt_id] SHALL be 1 during F0 only; all other ack bits SHALL be 0.
REQ-020 A requester SHALL deassert req in the cycle after its ack; a request still held is re-arbitrated as a new request.
REQ-021 Changes on sel inputs after the grant edge SHALL NOT affect the frame in progress.
REQ-022 Requests arriving during F0..GAP SHALL be held pending; none are lost or served mid-frame.
REQ-023 Latency: req rising in cycle t while in IDLE SHALL give ser_valid=1 in cycle t+1.
REQ-024 Minimum frame-to-frame spacing SHALL be 4+IDLE_GAP+1 cycles.
REQ-025 gnt_id SHALL hold its value from the grant edge until the next grant.
REQ-026 All outputs SHALL be glitch-free registered or pure state decodes.

Reset
REQ-027 rst low SHALL immediately force the following, regardless of clk:
- state=IDLE
- ptr=0
- gap counter=0
- latched sel=0
- gnt_id=0
- ack=0
- ser_out=1
- ser_valid=0
- busy=0
REQ-028 Reset mid-frame SHALL abort the frame with no further ser_valid; the first grant after release SHALL search from requester 0.

Configuration
REQ-029 With PATTERN_ARB_FRAME_CNT_EN defined:
- An extra output frame_cnt (8 bits) SHALL increment on each entry into F3.
- frame_cnt SHALL wrap 255->0.
- frame_cnt SHALL reset to 0.
REQ-030 Without PATTERN_ARB_FRAME_CNT_EN, the frame_cnt port and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-031 Single request: req=0001, sel0=2'b10, IDLE_GAP=1 -> ser_out 1,1,1,0 with ser_valid=1 for 4 cycles; ack=0001 in F0; gnt_id=0.
REQ-032 All request: req=1111 held until each ack, sel0..sel3 = 00,01,10,11 -> service order 0,1,2,3; frames 1100,1101,1110,1111; ack pulses 6 cycles apart.
REQ-033 Round-robin wrap: serve requester 2, then assert req=0101 -> requester 0 is served before requester 2 (ptr=3, search 3->0).
REQ-034 Sel change: sel1 changes from 11 to 00 in F1 of requester 1's frame -> frame still reads 1111.
REQ-035 Reset abort: rst low in F2 -> ser_valid=0, ser_out=1, busy=0 immediately; after release, req=1000 -> gnt_id=3, frame starts 1 cycle later.
REQ-036 With PATTERN_ARB_FRAME_CNT_EN: 257 frames -> frame_cnt=1; without the macro, the same bench compiles with no frame_cnt port.
